// File: rtl/rob.sv
// Reorder buffer: circular in-order retirement queue with CDB writeback,
// operand lookup bypass, and full flush on a mispredicted branch commit.
module rob #(
  parameter int ROB_SIZE  = 16,
  parameter int ROB_POS_W = 4,
  parameter int DATA_W    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 in_alloc_valid,
  input  logic [4:0]           in_alloc_dest_reg,
  output logic [ROB_POS_W-1:0] out_alloc_rob,
  output logic                 out_full,
  input  logic                 in_cdb_valid,
  input  logic [ROB_POS_W-1:0] in_cdb_rob,
  input  logic [DATA_W-1:0]    in_cdb_value,
  input  logic                 in_cdb_mispredict,
  input  logic [DATA_W-1:0]    in_cdb_target,
  input  logic [ROB_POS_W-1:0] in_query_rob1,
  input  logic [ROB_POS_W-1:0] in_query_rob2,
  output logic                 out_query_ready1,
  output logic                 out_query_ready2,
  output logic [DATA_W-1:0]    out_query_value1,
  output logic [DATA_W-1:0]    out_query_value2,
  output logic [4:0]           out_commit_reg,
  output logic [ROB_POS_W-1:0] out_commit_rob,
  output logic [DATA_W-1:0]    out_commit_value,
  output logic                 out_xbp,
  output logic [DATA_W-1:0]    out_xbp_pc
);

  localparam logic [ROB_POS_W:0]   FULL_CNT = (ROB_POS_W+1)'(ROB_SIZE);
  localparam logic [ROB_POS_W:0]   ONE_CNT  = (ROB_POS_W+1)'(1);
  localparam logic [ROB_POS_W-1:0] ONE_POS  = ROB_POS_W'(1);

  logic [ROB_POS_W-1:0] head, tail;
  logic [ROB_POS_W:0]   count;
  logic [ROB_SIZE-1:0]  busy, ready, mispredict;
  logic [4:0]           dest_reg [ROB_SIZE];
  logic [DATA_W-1:0]    value    [ROB_SIZE];
  logic [DATA_W-1:0]    target   [ROB_SIZE];

  logic alloc_fire, cdb_fire, commit_fire, flush;
  logic hit1, hit2;

  assign out_full      = (count == FULL_CNT);
  assign out_alloc_rob = tail;

  // out_full is taken from the pre-commit count, so a full ROB cannot
  // allocate even in the cycle its head retires.
  assign alloc_fire  = rdy && in_alloc_valid && !out_full && !out_xbp;
  assign cdb_fire    = rdy && in_cdb_valid && busy[in_cdb_rob];
  assign commit_fire = rdy && (count != '0) && busy[head] && ready[head];
  assign flush       = commit_fire && mispredict[head];

  assign hit1 = in_cdb_valid && (in_cdb_rob == in_query_rob1);
  assign hit2 = in_cdb_valid && (in_cdb_rob == in_query_rob2);

  assign out_query_ready1 = busy[in_query_rob1] && (ready[in_query_rob1] || hit1);
  assign out_query_ready2 = busy[in_query_rob2] && (ready[in_query_rob2] || hit2);
  assign out_query_value1 = !busy[in_query_rob1] ? '0 :
                            (hit1 ? in_cdb_value : value[in_query_rob1]);
  assign out_query_value2 = !busy[in_query_rob2] ? '0 :
                            (hit2 ? in_cdb_value : value[in_query_rob2]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head             <= '0;
      tail             <= '0;
      count            <= '0;
      busy             <= '0;
      ready            <= '0;
      mispredict       <= '0;
      out_commit_reg   <= '0;
      out_commit_rob   <= '0;
      out_commit_value <= '0;
      out_xbp          <= 1'b0;
      out_xbp_pc       <= '0;
    end else begin
      out_commit_reg <= '0;
      out_xbp        <= 1'b0;
      if (commit_fire) begin
        out_commit_reg   <= dest_reg[head];
        out_commit_rob   <= head;
        out_commit_value <= value[head];
        busy[head]       <= 1'b0;
        head             <= head + ONE_POS;
      end
      if (flush) begin
        // Everything younger than the branch is wrong-path work.
        out_xbp    <= 1'b1;
        out_xbp_pc <= target[head];
        busy       <= '0;
        ready      <= '0;
        mispredict <= '0;
        head       <= '0;
        tail       <= '0;
        count      <= '0;
      end else begin
        if (cdb_fire) begin
          ready[in_cdb_rob]      <= 1'b1;
          mispredict[in_cdb_rob] <= in_cdb_mispredict;
        end
        if (alloc_fire) begin
          busy[tail]       <= 1'b1;
          ready[tail]      <= 1'b0;
          mispredict[tail] <= 1'b0;
          tail             <= tail + ONE_POS;
        end
        if (alloc_fire && !commit_fire)
          count <= count + ONE_CNT;
        else if (!alloc_fire && commit_fire)
          count <= count - ONE_CNT;
      end
    end
  end

  // Payload storage needs no reset: it is only observed behind busy/ready.
  always_ff @(posedge clk) begin
    if (cdb_fire && !flush) begin
      value[in_cdb_rob]  <= in_cdb_value;
      target[in_cdb_rob] <= in_cdb_target;
    end
    if (alloc_fire && !flush)
      dest_reg[tail] <= in_alloc_dest_reg;
  end

endmodule

// File: tb/tb_rob.sv
// Bench for rob: hand vectors, directed corner sequences, and random traffic
// checked against a program-order queue model of the reorder buffer.
module tb_rob;
  localparam int N = 16;

  logic        clk = 1'b0;
  logic        rst, rdy, in_alloc_valid, in_cdb_valid, in_cdb_mispredict;
  logic [4:0]  in_alloc_dest_reg;
  logic [3:0]  in_cdb_rob, in_query_rob1, in_query_rob2;
  logic [31:0] in_cdb_value, in_cdb_target;
  logic [3:0]  out_alloc_rob, out_commit_rob;
  logic        out_full, out_query_ready1, out_query_ready2, out_xbp;
  logic [31:0] out_query_value1, out_query_value2, out_commit_value, out_xbp_pc;
  logic [4:0]  out_commit_reg;

  always #5 clk = ~clk;

  rob #(.ROB_SIZE(16), .ROB_POS_W(4), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .in_alloc_valid(in_alloc_valid), .in_alloc_dest_reg(in_alloc_dest_reg),
    .out_alloc_rob(out_alloc_rob), .out_full(out_full),
    .in_cdb_valid(in_cdb_valid), .in_cdb_rob(in_cdb_rob), .in_cdb_value(in_cdb_value),
    .in_cdb_mispredict(in_cdb_mispredict), .in_cdb_target(in_cdb_target),
    .in_query_rob1(in_query_rob1), .in_query_rob2(in_query_rob2),
    .out_query_ready1(out_query_ready1), .out_query_ready2(out_query_ready2),
    .out_query_value1(out_query_value1), .out_query_value2(out_query_value2),
    .out_commit_reg(out_commit_reg), .out_commit_rob(out_commit_rob),
    .out_commit_value(out_commit_value), .out_xbp(out_xbp), .out_xbp_pc(out_xbp_pc)
  );

  typedef struct {
    bit rdy; bit av; logic [4:0] dest;
    bit cv; logic [3:0] crob; logic [31:0] cval; bit cm; logic [31:0] ctgt;
    logic [3:0] q1; logic [3:0] q2;
  } in_t;

  typedef struct {
    in_t i;
    logic [3:0] arob; bit full; bit qr1; logic [31:0] qv1;
    logic [4:0] creg; logic [3:0] crob; logic [31:0] cval;
  } vec_t;

  typedef struct {
    int idx; logic [4:0] dest; bit done; logic [31:0] val; bit misp; logic [31:0] tgt;
  } ent_t;

  int n_pass = 0, n_total = 0;

  // Reference model: instructions in program order plus the head slot number.
  ent_t        mq[$];
  int          m_head;
  logic [4:0]  m_creg;
  logic [3:0]  m_crob;
  logic [31:0] m_cval, m_xpc;
  bit          m_xbp;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  function automatic void m_reset();
    mq.delete();
    m_head = 0; m_creg = '0; m_crob = '0; m_cval = '0; m_xbp = 0; m_xpc = '0;
  endfunction

  function automatic void m_query(input logic [3:0] q, input in_t s,
                                  output bit b, output bit r, output logic [31:0] v);
    bit hit;
    b = 0; r = 0; v = '0;
    hit = s.cv && (s.crob == q);
    foreach (mq[k]) if (mq[k].idx == int'(q)) begin
      b = 1;
      r = mq[k].done || hit;
      v = hit ? s.cval : mq[k].val;
    end
  endfunction

  function automatic void m_step(input in_t s);
    int   sz   = mq.size();
    int   aidx = (m_head + sz) % N;
    bit   xbp_before = m_xbp;
    bit   fl = 0;
    ent_t e;
    m_creg = '0;
    m_xbp  = 0;
    if (!s.rdy) return;
    if (sz > 0 && mq[0].done) begin
      m_creg = mq[0].dest; m_crob = 4'(mq[0].idx); m_cval = mq[0].val;
      fl = mq[0].misp;
      if (fl) m_xpc = mq[0].tgt;
      void'(mq.pop_front());
      m_head = (m_head + 1) % N;
    end
    if (fl) begin
      mq.delete(); m_head = 0; m_xbp = 1;
    end else begin
      if (s.cv) foreach (mq[k]) if (mq[k].idx == int'(s.crob)) begin
        mq[k].done = 1; mq[k].val = s.cval; mq[k].misp = s.cm; mq[k].tgt = s.ctgt;
      end
      if (s.av && sz < N && !xbp_before) begin
        e.idx = aidx; e.dest = s.dest; e.done = 0; e.val = '0; e.misp = 0; e.tgt = '0;
        mq.push_back(e);
      end
    end
  endfunction

  function automatic in_t idle();
    in_t s;
    s.rdy = 1; s.av = 0; s.dest = '0; s.cv = 0; s.crob = '0; s.cval = '0;
    s.cm = 0; s.ctgt = '0; s.q1 = 4'd9; s.q2 = 4'd9;
    return s;
  endfunction

  task automatic drive(input in_t s);
    rdy = s.rdy; in_alloc_valid = s.av; in_alloc_dest_reg = s.dest;
    in_cdb_valid = s.cv; in_cdb_rob = s.crob; in_cdb_value = s.cval;
    in_cdb_mispredict = s.cm; in_cdb_target = s.ctgt;
    in_query_rob1 = s.q1; in_query_rob2 = s.q2;
  endtask

  // One clock: combinational outputs checked mid-cycle, registered ones after the edge.
  task automatic step(input in_t s, output logic [3:0] arob, output bit full,
                      output bit qr1, output logic [31:0] qv1);
    bit b; bit r; logic [31:0] v;
    @(negedge clk);
    drive(s);
    #1;
    arob = out_alloc_rob; full = out_full; qr1 = out_query_ready1; qv1 = out_query_value1;
    chk("alloc_rob", out_alloc_rob, 32'((m_head + mq.size()) % N));
    chk("full", out_full, 32'(mq.size() == N));
    m_query(s.q1, s, b, r, v);
    chk("query_ready1", out_query_ready1, r);
    if (!(b && !r)) chk("query_value1", out_query_value1, v);
    m_query(s.q2, s, b, r, v);
    chk("query_ready2", out_query_ready2, r);
    if (!(b && !r)) chk("query_value2", out_query_value2, v);
    @(posedge clk);
    m_step(s);
    #1;
    chk("commit_reg", out_commit_reg, m_creg);
    chk("commit_rob", out_commit_rob, m_crob);
    chk("commit_value", out_commit_value, m_cval);
    chk("xbp", out_xbp, m_xbp);
    if (m_xbp) chk("xbp_pc", out_xbp_pc, m_xpc);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    drive(idle());
    @(negedge clk);
    rst = 1'b1;
    m_reset();
  endtask

  vec_t tv[$];
  task automatic add_vec(input in_t s, input logic [3:0] arob, input bit full, input bit qr1,
                         input logic [31:0] qv1, input logic [4:0] creg,
                         input logic [3:0] crob, input logic [31:0] cval);
    vec_t t;
    t.i = s; t.arob = arob; t.full = full; t.qr1 = qr1; t.qv1 = qv1;
    t.creg = creg; t.crob = crob; t.cval = cval;
    tv.push_back(t);
  endtask

  initial begin
    in_t s;
    logic [3:0] arob; bit full; bit qr1; logic [31:0] qv1;

    // Allocation order, out-of-order completion, in-order retirement, bypass lookup.
    s = idle(); s.av = 1; s.dest = 5; add_vec(s, 0, 0, 0, 0, 0, 0, 0);
    s.dest = 6;                       add_vec(s, 1, 0, 0, 0, 0, 0, 0);
    s.dest = 7;                       add_vec(s, 2, 0, 0, 0, 0, 0, 0);
    s.dest = 8; s.cv = 1; s.crob = 1; s.cval = 32'h11; s.q1 = 1;
                                      add_vec(s, 3, 0, 1, 32'h11, 0, 0, 0);
    s = idle(); s.cv = 1; s.crob = 0; s.cval = 32'h22; s.q1 = 1;
                                      add_vec(s, 4, 0, 1, 32'h11, 0, 0, 0);
    s = idle();                       add_vec(s, 4, 0, 0, 0, 5, 0, 32'h22);
                                      add_vec(s, 4, 0, 0, 0, 6, 1, 32'h11);
    s.cv = 1; s.crob = 3; s.cval = 32'hAB; s.q1 = 3;
                                      add_vec(s, 4, 0, 1, 32'hAB, 0, 1, 32'h11);
    s = idle(); s.q1 = 3;             add_vec(s, 4, 0, 1, 32'hAB, 0, 1, 32'h11);
    s.cv = 1; s.crob = 2; s.cval = 32'h33; s.q1 = 2;
                                      add_vec(s, 4, 0, 1, 32'h33, 0, 1, 32'h11);
    s = idle();                       add_vec(s, 4, 0, 0, 0, 7, 2, 32'h33);
                                      add_vec(s, 4, 0, 0, 0, 8, 3, 32'hAB);
                                      add_vec(s, 4, 0, 0, 0, 0, 3, 32'hAB);

    rst = 1'b0;
    drive(idle());
    #1;
    chk("rst_commit_reg", out_commit_reg, 0);
    chk("rst_commit_value", out_commit_value, 0);
    chk("rst_xbp", out_xbp, 0);
    chk("rst_alloc_rob", out_alloc_rob, 0);
    chk("rst_full", out_full, 0);
    m_reset();
    @(negedge clk);
    rst = 1'b1;

    foreach (tv[k]) begin
      step(tv[k].i, arob, full, qr1, qv1);
      chk($sformatf("tv%0d_alloc_rob", k), arob, tv[k].arob);
      chk($sformatf("tv%0d_full", k), full, tv[k].full);
      chk($sformatf("tv%0d_qready1", k), qr1, tv[k].qr1);
      chk($sformatf("tv%0d_qvalue1", k), qv1, tv[k].qv1);
      chk($sformatf("tv%0d_commit_reg", k), out_commit_reg, tv[k].creg);
      chk($sformatf("tv%0d_commit_rob", k), out_commit_rob, tv[k].crob);
      chk($sformatf("tv%0d_commit_value", k), out_commit_value, tv[k].cval);
    end

    // Fill to capacity, overflow attempt, commit-while-full, wrap of the tail.
    do_reset();
    for (int i = 0; i < N; i++) begin
      s = idle(); s.av = 1; s.dest = 5'(i + 1);
      step(s, arob, full, qr1, qv1);
    end
    chk("full_at_16", out_full, 1);
    s = idle(); s.av = 1; s.dest = 5'd20;
    step(s, arob, full, qr1, qv1);
    chk("ovf_full", out_full, 1);
    chk("ovf_alloc_rob", out_alloc_rob, 0);
    s = idle(); s.cv = 1; s.crob = 0; s.cval = 32'hC0;
    step(s, arob, full, qr1, qv1);
    s = idle(); s.av = 1; s.dest = 5'd21;
    step(s, arob, full, qr1, qv1);
    chk("full_commit_reg", out_commit_reg, 1);
    chk("full_alloc_blocked", out_full, 0);
    chk("wrap_alloc_rob", out_alloc_rob, 0);
    s = idle(); s.av = 1; s.dest = 5'd22;
    step(s, arob, full, qr1, qv1);
    chk("wrap_got_index", arob, 0);
    chk("refull", out_full, 1);

    // Mispredict at the head flushes younger work and drops same-cycle traffic.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      s = idle(); s.av = 1; s.dest = 5'(i + 1);
      step(s, arob, full, qr1, qv1);
    end
    s = idle(); s.cv = 1; s.crob = 0; s.cval = 32'h44; s.cm = 1; s.ctgt = 32'h100;
    step(s, arob, full, qr1, qv1);
    s = idle(); s.av = 1; s.dest = 5'd9; s.cv = 1; s.crob = 2; s.cval = 32'h5;
    step(s, arob, full, qr1, qv1);
    chk("xbp_pulse", out_xbp, 1);
    chk("xbp_pc", out_xbp_pc, 32'h100);
    chk("xbp_commit_reg", out_commit_reg, 1);
    chk("xbp_flushed_tail", out_alloc_rob, 0);
    s = idle(); s.av = 1; s.dest = 5'd10; s.q1 = 1;
    step(s, arob, full, qr1, qv1);
    chk("xbp_alloc_ignored", out_alloc_rob, 0);
    chk("xbp_single_cycle", out_xbp, 0);
    chk("xbp_query_flushed", qr1, 0);
    step(s, arob, full, qr1, qv1);
    chk("post_flush_index", arob, 0);

    // Freeze: head ready but rdy low for three cycles.
    do_reset();
    s = idle(); s.av = 1; s.dest = 5'd9;
    step(s, arob, full, qr1, qv1);
    s = idle(); s.cv = 1; s.crob = 0; s.cval = 32'h55;
    step(s, arob, full, qr1, qv1);
    for (int i = 0; i < 3; i++) begin
      s = idle(); s.rdy = 0; s.av = 1; s.dest = 5'd3;
      step(s, arob, full, qr1, qv1);
      chk("frozen_commit_reg", out_commit_reg, 0);
      chk("frozen_tail", out_alloc_rob, 1);
    end
    s = idle();
    step(s, arob, full, qr1, qv1);
    chk("thaw_commit_reg", out_commit_reg, 9);
    chk("thaw_commit_value", out_commit_value, 32'h55);

    // Reset pulse between edges with work in flight.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      s = idle(); s.av = 1; s.dest = 5'(i + 1);
      step(s, arob, full, qr1, qv1);
    end
    s = idle(); s.cv = 1; s.crob = 0; s.cval = 32'h77;
    step(s, arob, full, qr1, qv1);
    s = idle(); s.q1 = 1;
    step(s, arob, full, qr1, qv1);
    chk("pre_rst_commit_value", out_commit_value, 32'h77);
    #2 rst = 1'b0;
    #1;
    chk("async_commit_reg", out_commit_reg, 0);
    chk("async_commit_value", out_commit_value, 0);
    chk("async_alloc_rob", out_alloc_rob, 0);
    chk("async_query_ready", out_query_ready1, 0);
    chk("async_query_value", out_query_value1, 0);
    #1 rst = 1'b1;
    m_reset();
    s = idle(); s.av = 1; s.dest = 5'd12;
    step(s, arob, full, qr1, qv1);
    chk("post_rst_index", arob, 0);

    // Random traffic against the queue model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      s = idle();
      s.rdy  = ($urandom_range(9) != 0);
      s.av   = ($urandom_range(9) < 6);
      s.dest = 5'($urandom);
      s.cv   = ($urandom_range(1) == 1);
      if (mq.size() > 0 && $urandom_range(3) != 0)
        s.crob = 4'(mq[$urandom_range(mq.size() - 1)].idx);
      else
        s.crob = 4'($urandom);
      s.cval = $urandom;
      s.cm   = ($urandom_range(24) == 0);
      s.ctgt = $urandom;
      s.q1   = 4'($urandom);
      s.q2   = (mq.size() > 0) ? 4'(mq[$urandom_range(mq.size() - 1)].idx) : 4'($urandom);
      step(s, arob, full, qr1, qv1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
